dm_sync: RTL

//  Synchronous-read, byte-enabled data memory for the MEM stage. Sub-word store merging and load extension are built in.

---
 rtl/dm_pkg.sv | 47 ++++
 rtl/dm_lane_ext.sv | 35 +++
 rtl/dm_sync.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - op encodings, FSM states and alignment helper for dm_sync
//
// Purpose : constants shared by dm_sync, dm_lane_ext and the bench.
//   Load ops : DM_OP_W, DM_OP_BU, DM_OP_B, DM_OP_HU, DM_OP_H (others act as LW)
//   Store ops: DM_ST_W, DM_ST_B, DM_ST_H (others act as SW)
//   States   : ST_CLEAR, ST_IDLE
package dm_pkg;

   localparam logic [2:0] DM_OP_W  = 3'd0;
   localparam logic [2:0] DM_OP_BU = 3'd1;
   localparam logic [2:0] DM_OP_B  = 3'd2;
   localparam logic [2:0] DM_OP_HU = 3'd3;
   localparam logic [2:0] DM_OP_H  = 3'd4;

   localparam logic [2:0] DM_ST_W  = 3'd0;
   localparam logic [2:0] DM_ST_B  = 3'd1;
   localparam logic [2:0] DM_ST_H  = 3'd2;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } dm_state_t;

   // Store and load op spaces overlap numerically, so the access direction
   // selects which table decides the access width.
   function automatic logic dm_misaligned(input logic       i_store,
                                          input logic [2:0] i_op,
                                          input logic [1:0] i_off);
      logic w_mis;
      w_mis = |i_off;
      if (i_store) begin
         case (i_op)
            DM_ST_B: w_mis = 1'b0;
            DM_ST_H: w_mis = i_off[0];
            default: w_mis = |i_off;
         endcase
      end else begin
         case (i_op)
            DM_OP_BU, DM_OP_B: w_mis = 1'b0;
            DM_OP_HU, DM_OP_H: w_mis = i_off[0];
            default:           w_mis = |i_off;
         endcase
      end
      return w_mis;
   endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// rtl/dm_lane_ext.sv - load lane extract and zero/sign extension
//
// Purpose : picks the byte/half addressed by i_off out of a memory word and
//           extends it according to the load op; unknown ops pass the word.
// Ports   : i_word [31:0] raw memory word
//           i_off  [1:0]  byte offset A[1:0]
//           i_op   [2:0]  load op (dm_pkg encodings)
//           o_data [31:0] extended load result
module dm_lane_ext
   import dm_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_op,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_word[{i_off, 3'b000} +: 8];
   assign w_half = i_word[{i_off[1], 4'b0000} +: 16];

   always_comb begin
      o_data = i_word;
      case (i_op)
         DM_OP_BU: o_data = {24'h0, w_byte};
         DM_OP_B:  o_data = {{24{w_byte[7]}}, w_byte};
         DM_OP_HU: o_data = {16'h0, w_half};
         DM_OP_H:  o_data = {{16{w_half[15]}}, w_half};
         default:  o_data = i_word;
      endcase
   end

endmodule

// File: rtl/dm_sync.sv
// rtl/dm_sync.sv - byte-enabled synchronous data memory with clear FSM
//
// Purpose : MEM-stage data memory. Sub-word stores merge into the addressed
//           word, loads return an extended value one cycle after accept,
//           misaligned accesses are dropped and flagged. After reset the
//           array is zeroed one word per cycle before ready rises.
// Config  : DM_TRACE_EN - print every accepted aligned store.
// Ports   : clk, Reset (async, active high)
//           req, we, op[2:0], A[31:0], WD[31:0], PC[31:0]   request side
//           ready                                           1 once cleared
//           RD[31:0], rvalid, misalign                      response side
module dm_sync
   import dm_pkg::*;
#(
   parameter  int SIZE = 4096,
   localparam int AW   = $clog2(SIZE)
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   input  logic [31:0] PC,
   output logic        ready,
   output logic [31:0] RD,
   output logic        rvalid,
   output logic        misalign
);

   dm_state_t   r_state, w_state_nxt;
   logic [AW-1:0] r_clr_idx;
   logic [31:0] r_mem [SIZE];
   logic [31:0] r_rd;
   logic        r_rvalid, r_misalign;

   logic [AW-1:0] w_idx, w_widx;
   logic        w_accept, w_mis, w_store_ok, w_load_ok;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_ld_data;

   assign ready      = (r_state == ST_IDLE);
   assign w_idx      = A[AW+1:2];
   assign w_accept   = req && ready;
   assign w_mis      = dm_misaligned(we, op, A[1:0]);
   assign w_store_ok = w_accept && we && !w_mis;
   assign w_load_ok  = w_accept && !we && !w_mis;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_CLEAR: if (r_clr_idx == AW'(SIZE - 1)) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_state    <= ST_CLEAR;
         r_clr_idx  <= '0;
         r_rd       <= '0;
         r_rvalid   <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
         r_rvalid   <= w_load_ok;
         r_misalign <= w_accept && w_mis;
         if (w_load_ok) r_rd <= w_ld_data;
      end
   end

   // Clearing and stores share one byte-enabled write port.
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = 32'h0;
      w_widx  = w_idx;
      if (r_state == ST_CLEAR) begin
         w_be   = 4'b1111;
         w_widx = r_clr_idx;
      end else if (w_store_ok) begin
         case (op)
            DM_ST_B: begin
               w_be    = 4'b0001 << A[1:0];
               w_wdata = {4{WD[7:0]}};
            end
            DM_ST_H: begin
               w_be    = A[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{WD[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = WD;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (w_be[i]) r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
   end

   // The read sees the array as left by the previous edge, so a load right
   // after a store to the same word returns the merged data.
   dm_lane_ext u_lane_ext (
      .i_word (r_mem[w_idx]),
      .i_off  (A[1:0]),
      .i_op   (op),
      .o_data (w_ld_data)
   );

   assign RD       = r_rd;
   assign rvalid   = r_rvalid;
   assign misalign = r_misalign;

`ifdef DM_TRACE_EN
   logic [31:0] w_merged;
   always_comb begin
      w_merged = r_mem[w_idx];
      for (int i = 0; i < 4; i++) begin
         if (w_be[i]) w_merged[8*i +: 8] = w_wdata[8*i +: 8];
      end
   end
   always_ff @(posedge clk) begin
      if (w_store_ok) $display("%d@%h: *%h <= %h", $time, PC, {A[31:2], 2'b00}, w_merged);
   end
   logic w_unused;
   assign w_unused = ^A[31:AW+2];
`else
   logic w_unused;
   assign w_unused = ^{PC, A[31:AW+2]};
`endif

endmodule
